// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the PC generator stage.
package pc_gen_pkg;

  localparam int unsigned PC_W = 64;

  localparam logic [PC_W-1:0] BOOT_PC = 64'h0000_0000_0000_0000;
  localparam logic [PC_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    WAIT_REDIR = 2'd2
  } pcgen_state_t;

endpackage

// File: rtl/pc_gen_fifo.sv
// Synchronous FIFO holding issued PCs until decode consumes the matching instruction.
module pc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Flush dominates; full/empty guard against protocol violations.
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential/redirect PC selection, fetch handshake and in-flight PC queue.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = BOOT_PC,
  parameter int unsigned PCQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [63:0] pc_o,
  output logic        pc_valid_o,
  input  logic        pc_ready_i,
  output logic        kill_o,
  input  logic        fetch_exc_i,
  input  logic        instr_accept_i,
  output logic [63:0] dec_pc_o,
  output logic        dec_pc_valid_o,
  input  logic        br_redirect_i,
  input  logic [63:0] br_target_i,
  input  logic        trap_redirect_i,
  input  logic [63:0] trap_target_i
);

  pcgen_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redir_target;
  logic            redirect;
  logic            issue;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;

  assign redirect     = br_redirect_i | trap_redirect_i;
  assign redir_target = trap_redirect_i ? trap_target_i : br_target_i;
  assign kill_o       = redirect;
  assign pc_o         = pc_q;
  assign issue        = pc_valid_o & pc_ready_i;
  // A faulting fetch is neither queued nor advanced past; execution waits for a redirect.
  assign push         = issue & ~fetch_exc_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_valid_o = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        pc_valid_o = ~fifo_full & ~redirect;
        if (pc_valid_o & pc_ready_i & fetch_exc_i) state_d = WAIT_REDIR;
      end
      WAIT_REDIR: state_d = WAIT_REDIR;
      default:    state_d = BOOT;
    endcase
    if (redirect) state_d = RUN;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redir_target;
    else if (push) pc_d = pc_q + PC_STEP;
  end

  pc_fifo #(
    .DEPTH (PCQ_DEPTH),
    .WIDTH (PC_W)
  ) u_pcq (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (instr_accept_i),
    .flush  (redirect),
    .din    (pc_q),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (dec_pc_o)
  );

  assign dec_pc_valid_o = ~fifo_empty;

  // Decode must never accept an instruction when no PC is queued.
  always_ff @(posedge clk) begin
    if (resetn) assert (!(instr_accept_i && fifo_empty));
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
module tb_pc_gen;

  logic        clk;
  logic        resetn;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        pc_ready_i;
  logic        kill_o;
  logic        fetch_exc_i;
  logic        instr_accept_i;
  logic [63:0] dec_pc_o;
  logic        dec_pc_valid_o;
  logic        br_redirect_i;
  logic [63:0] br_target_i;
  logic        trap_redirect_i;
  logic [63:0] trap_target_i;

  int checks   = 0;
  int failures = 0;

  pc_gen #(.RESET_PC(64'h0), .PCQ_DEPTH(4)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .pc_ready_i      (pc_ready_i),
    .kill_o          (kill_o),
    .fetch_exc_i     (fetch_exc_i),
    .instr_accept_i  (instr_accept_i),
    .dec_pc_o        (dec_pc_o),
    .dec_pc_valid_o  (dec_pc_valid_o),
    .br_redirect_i   (br_redirect_i),
    .br_target_i     (br_target_i),
    .trap_redirect_i (trap_redirect_i),
    .trap_target_i   (trap_target_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the active edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; pc_ready_i = 1'b1; fetch_exc_i = 1'b0; instr_accept_i = 1'b0;
    br_redirect_i = 1'b0; br_target_i = '0; trap_redirect_i = 1'b0; trap_target_i = '0;
    tick(); tick();
    chk("rst_valid", 64'(pc_valid_o), 64'd0);
    chk("rst_kill", 64'(kill_o), 64'd0);
    chk("rst_dec_valid", 64'(dec_pc_valid_o), 64'd0);
    chk("rst_dec_pc", dec_pc_o, 64'h0);
    resetn = 1'b1; #1;
    chk("boot_valid", 64'(pc_valid_o), 64'd0);

    // Sequential issue until the queue fills.
    tick(); chk("issue0_valid", 64'(pc_valid_o), 64'd1); chk("issue0_pc", pc_o, 64'h0);
    tick(); chk("issue1_pc", pc_o, 64'h4);
    tick(); chk("issue2_pc", pc_o, 64'h8);
    tick(); chk("issue3_pc", pc_o, 64'hC);
    tick(); chk("full_valid", 64'(pc_valid_o), 64'd0);
    chk("full_dec_pc", dec_pc_o, 64'h0); chk("full_dec_valid", 64'(dec_pc_valid_o), 64'd1);
    tick(); chk("full_hold_valid", 64'(pc_valid_o), 64'd0);
    instr_accept_i = 1'b1;
    tick(); instr_accept_i = 1'b0; #1;
    chk("pop_dec_pc", dec_pc_o, 64'h4);
    chk("pop_valid", 64'(pc_valid_o), 64'd1); chk("pop_pc", pc_o, 64'h10);
    tick(); chk("refull_valid", 64'(pc_valid_o), 64'd0);

    // Mid-operation reset discards everything.
    resetn = 1'b0; #1;
    chk("midrst_valid", 64'(pc_valid_o), 64'd0);
    chk("midrst_dec_valid", 64'(dec_pc_valid_o), 64'd0);
    chk("midrst_pc", pc_o, 64'h0);
    tick(); resetn = 1'b1;
    tick(); tick(); tick(); pc_ready_i = 1'b0; #1;
    chk("bp_start_pc", pc_o, 64'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", pc_o, 64'h8);
      chk("bp_hold_valid", 64'(pc_valid_o), 64'd1);
    end
    pc_ready_i = 1'b1;
    tick(); pc_ready_i = 1'b0; #1;
    chk("bp_release_pc", pc_o, 64'hC);
    chk("bp_head", dec_pc_o, 64'h0);
    // Exactly three entries (0,4,8) must be queued.
    instr_accept_i = 1'b1;
    tick(); tick(); tick(); instr_accept_i = 1'b0; #1;
    chk("bp_drained", 64'(dec_pc_valid_o), 64'd0);
    chk("bp_drained_pc", dec_pc_o, 64'h0);

    // Branch redirect with three queued PCs.
    pc_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("pre_br_head", dec_pc_o, 64'hC);
    br_redirect_i = 1'b1; br_target_i = 64'h8000_0100; #1;
    chk("br_kill", 64'(kill_o), 64'd1);
    chk("br_valid", 64'(pc_valid_o), 64'd0);
    tick(); br_redirect_i = 1'b0; #1;
    chk("br_flush", 64'(dec_pc_valid_o), 64'd0);
    chk("br_pc", pc_o, 64'h8000_0100);
    chk("br_valid_next", 64'(pc_valid_o), 64'd1);
    chk("br_kill_next", 64'(kill_o), 64'd0);

    // Trap wins over a simultaneous branch.
    trap_redirect_i = 1'b1; trap_target_i = 64'h8000_0000;
    br_redirect_i = 1'b1; br_target_i = 64'h8000_2000; #1;
    chk("both_kill", 64'(kill_o), 64'd1);
    tick(); trap_redirect_i = 1'b0; br_redirect_i = 1'b0; #1;
    chk("both_pc", pc_o, 64'h8000_0000);
    chk("both_flush", 64'(dec_pc_valid_o), 64'd0);

    // Queue two PCs, then fault on 0xA000_0000.
    br_redirect_i = 1'b1; br_target_i = 64'h9FFF_FFF8;
    tick(); br_redirect_i = 1'b0;
    tick(); tick();
    fetch_exc_i = 1'b1; #1;
    chk("exc_issue_pc", pc_o, 64'hA000_0000);
    chk("exc_issue_valid", 64'(pc_valid_o), 64'd1);
    tick(); fetch_exc_i = 1'b0; #1;
    chk("exc_head", dec_pc_o, 64'h9FFF_FFF8);
    for (int i = 0; i < 10; i++) begin
      chk("exc_idle_valid", 64'(pc_valid_o), 64'd0);
      chk("exc_idle_pc", pc_o, 64'hA000_0000);
      tick();
    end
    instr_accept_i = 1'b1;
    tick(); tick(); instr_accept_i = 1'b0; #1;
    chk("exc_fifo_two", 64'(dec_pc_valid_o), 64'd0);
    trap_redirect_i = 1'b1; trap_target_i = 64'h8000_0004; #1;
    chk("exc_trap_kill", 64'(kill_o), 64'd1);
    tick(); trap_redirect_i = 1'b0; #1;
    chk("exc_resume_pc", pc_o, 64'h8000_0004);
    chk("exc_resume_valid", 64'(pc_valid_o), 64'd1);

    // Unaligned target passes through; increment wraps at 64 bits.
    br_redirect_i = 1'b1; br_target_i = 64'hFFFF_FFFF_FFFF_FFFE;
    tick(); br_redirect_i = 1'b0; #1;
    chk("unaligned_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFE);
    tick(); chk("wrap_pc", pc_o, 64'h2);
    chk("wrap_head", dec_pc_o, 64'hFFFF_FFFF_FFFF_FFFE);

    // Redirect taken in BOOT.
    resetn = 1'b0;
    tick(); resetn = 1'b1; br_redirect_i = 1'b1; br_target_i = 64'h1234; #1;
    chk("boot_br_valid", 64'(pc_valid_o), 64'd0);
    chk("boot_br_kill", 64'(kill_o), 64'd1);
    tick(); br_redirect_i = 1'b0; #1;
    chk("boot_br_pc", pc_o, 64'h1234);
    chk("boot_br_run", 64'(pc_valid_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
